// File: rtl/mem_dump_pkg.sv
// Shared types and default widths for the memory dump reader.
package mem_dump_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Walks a memory read port over an inclusive, wrapping address range and streams
// (addr, word) pairs out on valid/ready. Optional running checksum: MEM_DUMP_CHKSUM_EN.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
`ifdef MEM_DUMP_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  // Only latencies 0 and 1 are meaningful, so a single bit counts the wait.
  localparam logic LAT_MAX = (RD_LAT != 0) ? 1'b1 : 1'b0;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_lat;
`ifdef MEM_DUMP_CHKSUM_EN
  logic [DATA_W-1:0] r_chksum;
`endif

  logic              w_hs;
  logic              w_last;
  logic [ADDR_W-1:0] w_next;

  assign w_hs   = r_out_valid && out_ready;
  assign w_last = (r_cur == r_end);
  assign w_next = r_cur + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_end       <= '0;
      r_rd_addr   <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lat       <= 1'b0;
`ifdef MEM_DUMP_CHKSUM_EN
      r_chksum    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cur     <= start_addr;
            r_end     <= end_addr;
            r_rd_addr <= start_addr;
            r_lat     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= READ;
`ifdef MEM_DUMP_CHKSUM_EN
            r_chksum  <= '0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        READ: begin
          if (r_lat == LAT_MAX) begin
            r_out_data  <= rd_data;
            r_out_addr  <= r_cur;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        HOLD: begin
          // Output registers are frozen until the consumer takes the word.
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_lat       <= 1'b0;
`ifdef MEM_DUMP_CHKSUM_EN
            r_chksum    <= r_chksum + r_out_data;
`endif
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cur     <= w_next;
              r_rd_addr <= w_next;
              r_state   <= READ;
            end
          end else begin
            r_state <= HOLD;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign busy      = r_busy;
  assign done      = r_done;
`ifdef MEM_DUMP_CHKSUM_EN
  assign chksum    = r_chksum;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed/randomized bench for mem_dump_reader with RD_LAT=0 and RD_LAT=1 instances
// checked against a queue-based model of the dumped range.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [7:0]  start_addr, end_addr;
  logic        out_ready;
  logic [7:0]  rd_addr0, rd_addr1, out_addr0, out_addr1;
  logic [31:0] rd_data0, rd_data1, out_data0, out_data1;
  logic        out_valid0, out_valid1, busy0, busy1, done0, done1;
`ifdef MEM_DUMP_CHKSUM_EN
  logic [31:0] chksum0, chksum1;
`endif

  logic [31:0] mem [256];
  logic        sel;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  // Async-read memory for the RD_LAT=0 instance, registered read for RD_LAT=1.
  assign rd_data0 = mem[rd_addr0];
  always @(posedge clk) rd_data1 <= mem[rd_addr1];

  mem_dump_reader #(.ADDR_W(8), .DATA_W(32), .RD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .start_addr(start_addr), .end_addr(end_addr),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_addr(out_addr0), .busy(busy0), .done(done0)
`ifdef MEM_DUMP_CHKSUM_EN
    , .chksum(chksum0)
`endif
  );

  mem_dump_reader #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .start_addr(start_addr), .end_addr(end_addr),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_addr(out_addr1), .busy(busy1), .done(done1)
`ifdef MEM_DUMP_CHKSUM_EN
    , .chksum(chksum1)
`endif
  );

  wire        w_valid = sel ? out_valid1 : out_valid0;
  wire [7:0]  w_addr  = sel ? out_addr1  : out_addr0;
  wire [31:0] w_data  = sel ? out_data1  : out_data0;
  wire        w_busy  = sel ? busy1      : busy0;
  wire        w_done  = sel ? done1      : done0;
`ifdef MEM_DUMP_CHKSUM_EN
  wire [31:0] w_chk   = sel ? chksum1    : chksum0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Occasionally pulse start on the busy instance with a junk range; it must be ignored.
  task automatic poke(input logic s, input bit en);
    logic v;
    v = en && ($urandom_range(0, 3) == 0);
    if (s) start1 = v; else start0 = v;
    if (v) begin
      start_addr = 8'($urandom);
      end_addr   = 8'($urandom);
    end
  endtask

  task automatic run_dump(input logic s, input logic [7:0] sa, input logic [7:0] ea,
                          input bit rnd, input int stall_addr, input int stall_n);
    logic [7:0]  a;
    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] sum;
    int          n, stalls;
    a = sa;
    sum = 32'd0;
    for (int k = 0; k < 256; k++) begin
      q_addr.push_back(a);
      q_data.push_back(mem[a]);
      sum = sum + mem[a];
      if (a == ea) break;
      a = a + 8'd1;
    end
    sel = s;
    @(negedge clk);
    start_addr = sa;
    end_addr   = ea;
    out_ready  = 1'b0;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check("busy_after_start", w_busy, 1'b1);
`ifdef MEM_DUMP_CHKSUM_EN
    check("chksum_cleared", w_chk, 32'd0);
`endif
    n = 1;
    while (!w_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_latency", n, s ? 32'd3 : 32'd2);
    for (int i = 0; i < q_addr.size(); i++) begin
      if (i > 0) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
          if (!w_valid) begin
            out_ready = 1'($urandom);
            poke(s, rnd);
          end
        end while (!w_valid && n < 20);
        check("word_gap", n, s ? 32'd2 : 32'd1);
      end
      check("out_addr", w_addr, q_addr[i]);
      check("out_data", w_data, q_data[i]);
      check("done_early", w_done, 1'b0);
      stalls = (int'(q_addr[i]) == stall_addr) ? stall_n : (rnd ? $urandom_range(0, 2) : 0);
      for (int k = 0; k < stalls; k++) begin
        out_ready = 1'b0;
        poke(s, rnd);
        @(negedge clk);
        check("stall_valid", w_valid, 1'b1);
        check("stall_addr", w_addr, q_addr[i]);
        check("stall_data", w_data, q_data[i]);
      end
      out_ready = 1'b1;
      poke(s, rnd);
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      out_ready = rnd ? 1'($urandom) : 1'b0;
      check("valid_dropped", w_valid, 1'b0);
      if (i == q_addr.size() - 1) begin
        check("done_pulse", w_done, 1'b1);
        check("busy_in_done", w_busy, 1'b1);
`ifdef MEM_DUMP_CHKSUM_EN
        check("chksum_final", w_chk, sum);
`endif
        @(negedge clk);
        check("done_one_cycle", w_done, 1'b0);
        check("idle_after_done", w_busy, 1'b0);
      end else begin
        check("done_mid", w_done, 1'b0);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start_addr = 8'd0;
    end_addr = 8'd0;
    out_ready = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 4 + 32'h100);
    repeat (3) @(negedge clk);
    check("rst_valid", {out_valid1, out_valid0}, 2'b00);
    check("rst_busy", {busy1, busy0}, 2'b00);
    check("rst_done", {done1, done0}, 2'b00);
    check("rst_rd_addr", {rd_addr1, rd_addr0}, 16'd0);
    check("rst_out_addr", {out_addr1, out_addr0}, 16'd0);
    check("rst_out_data", out_data0 | out_data1, 32'd0);
    rst = 1'b0;

    // Reset while a word is being held.
    @(negedge clk);
    start_addr = 8'd3;
    end_addr = 8'd6;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_valid", out_valid0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", out_valid0, 1'b0);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_rd_addr", rd_addr0, 8'd0);
    check("midrst_done", done0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done0, 1'b0);
    end
    run_dump(1'b0, 8'd2, 8'd2, 1'b0, -1, 0);

    // Basic range and backpressure on word 4.
    run_dump(1'b0, 8'd3, 8'd6, 1'b0, -1, 0);
    run_dump(1'b0, 8'd3, 8'd6, 1'b0, 4, 5);

    // Wrap-around and full range on random contents, with junk starts while busy.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    run_dump(1'b0, 8'hFE, 8'h01, 1'b1, -1, 0);
    run_dump(1'b0, 8'h00, 8'hFF, 1'b1, -1, 0);

    // Registered-read instance.
    run_dump(1'b1, 8'd3, 8'd6, 1'b1, 5, 3);
    run_dump(1'b1, 8'hFE, 8'h01, 1'b1, -1, 0);
    run_dump(1'b1, 8'h00, 8'hFF, 1'b1, -1, 0);
    run_dump(1'b1, 8'h80, 8'h80, 1'b1, -1, 0);

    // Checksum wrap: 1 + 2 + 0xFFFFFFFF = 2.
    mem[8'h10] = 32'h0000_0001;
    mem[8'h11] = 32'h0000_0002;
    mem[8'h12] = 32'hFFFF_FFFF;
    run_dump(1'b0, 8'h10, 8'h12, 1'b0, -1, 0);
`ifdef MEM_DUMP_CHKSUM_EN
    check("chksum_hold", chksum0, 32'h0000_0002);
`endif
    run_dump(1'b0, 8'h20, 8'h21, 1'b1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Read-side companion to the dual-port data memory. Walks the memory's read port (address out, data in) over an inclusive address range.
- Emits each word with its address on a valid/ready stream, for the debug unit, display or UART dumper.
- Never writes memory. It sits beside the CPU, which owns the write port.

Parameters:
- ADDR_W, 8, width of the memory read address.
- DATA_W, 32, width of a memory word.
- RD_LAT, 0, cycles from rd_addr change to valid rd_data. Legal values are 0 (distributed RAM, async read) or 1 (registered read).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- start_addr  input  ADDR_W  first address of the range; latched on accepted start.
- end_addr  input  ADDR_W  last address of the range (inclusive); latched on accepted start.
- rd_addr  output  ADDR_W  address to the memory read port.
- rd_data  input  DATA_W  data from the memory read port.
- out_valid  output  1  out_data/out_addr hold a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  DATA_W  captured word.
- out_addr  output  ADDR_W  address of out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: state IDLE; rd_addr, out_data, out_addr, the current pointer cur and latched end all 0; out_valid, busy and done all 0.
- Reset mid-dump: abandons the dump immediately and drops out_valid. No partial done pulse.
- IDLE, start=1: cur<=start_addr, end<=end_addr, go to READ.
- IDLE, start=0: stay in IDLE.
- READ: rd_addr=cur, registered and driven continuously.
  - Latency counter lat counts 0..RD_LAT.
  - When lat==RD_LAT: out_data<=rd_data, out_addr<=cur, out_valid<=1, go to HOLD.
- HOLD: out_valid, out_data and out_addr stay stable until handshake. They never change while out_valid=1 && !out_ready.
  - On handshake, out_valid<=0.
  - If cur==end, go to DONE.
  - Otherwise cur<=cur+1 (mod 2^ADDR_W), go to READ.
- DONE: done=1 for exactly this cycle, busy=1, then IDLE.
- Latency with RD_LAT=0:
  - start sampled at edge 0; READ occupies cycle 1; out_valid is high from cycle 2.
  - Throughput is one word per 2 cycles when out_ready=1.
  - RD_LAT=1 adds one cycle per word.
- Range rules:
  - start_addr==end_addr gives exactly one word.
  - end_addr<start_addr wraps 2^ADDR_W-1 -> 0 and continues until cur==end.
  - 0..255 (ADDR_W=8) gives 256 words.
- start while busy is ignored; range inputs are not re-latched.
- start and the final handshake in the same cycle: start is ignored (state is HOLD, not IDLE).
- out_ready is ignored while out_valid=0.
- rd_data is sampled only at the capture cycle; other values are don't-care.

Optional Feature:
- Macro MEM_DUMP_CHKSUM_EN.
- Defined:
  - Adds output port chksum (DATA_W), reset 0, cleared on accepted start.
  - chksum<=chksum+out_data (mod 2^DATA_W) on each handshake.
  - Final value is valid from the done cycle until the next accepted start.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_dump_pkg holds:
  - state enum {IDLE, READ, HOLD, DONE}, 2 bits;
  - default constants ADDR_W_DEF=8, DATA_W_DEF=32.
- No sub-module. The FSM, address pointer and capture register form one block; the checksum is a few lines under the macro.

Test Plan:
- Reset mid-dump: rst=1 during HOLD -> next cycle out_valid=0, busy=0, rd_addr=0, no done pulse; then start, start_addr=2, end_addr=2 -> single word addr 2 emitted normally.
- Basic dump: mem[i]=i*4+0x100; start_addr=3, end_addr=6, out_ready=1, RD_LAT=0 -> words (3,0x10C),(4,0x110),(5,0x114),(6,0x118) in order; out_valid first high 2 cycles after start; done one cycle after the last handshake.
- Backpressure: same range, out_ready=0 for 5 cycles on word 4 -> out_data holds 0x110 and out_addr holds 4 for all 5 cycles; no word is dropped or duplicated.
- Wrap: start_addr=0xFE, end_addr=0x01 -> addresses FE, FF, 00, 01, then done; with start_addr=0x00, end_addr=0xFF -> exactly 256 words.
- Ignored start and RD_LAT=1:
  - start pulses while busy -> the range is unchanged;
  - RD_LAT=1 with a bench memory modelling one-cycle read latency -> each captured word matches mem[rd_addr] presented one cycle earlier.
- Checksum (MEM_DUMP_CHKSUM_EN defined): words 0x1,0x2,0xFFFFFFFF -> chksum=0x00000002 at done; a new start clears it to 0.
